// File: rtl/imem_loader.sv
// imem_loader: receives a framed program image over a byte stream and
// writes 32-bit instruction words into the instruction RAM.
module imem_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic              busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int NW = ADDR_W + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [NW-1:0] N_FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0]    SYNC    = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_DATA,
        S_CHECK
    } state_t;

    state_t            r_state, w_state;
    logic [NW-1:0]     r_n, w_n;
    logic [ADDR_W-1:0] r_widx, w_widx;
    logic [1:0]        r_bidx, w_bidx;
    logic [23:0]       r_asm, w_asm;
    logic [7:0]        r_sum, w_sum;
    logic [TW-1:0]     r_idle, w_idle;
    logic              r_we, w_we;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [31:0]       r_wdata, w_wdata;
    logic              r_hold, w_hold;
    logic              r_done, w_done;
    logic              r_err, w_err;

    logic [31:0]       w_word;
    logic              w_last_word;
    logic              w_timeout;

    // Word completed by the current byte; only the low 3 bytes are kept
    assign w_word      = {r_asm, rx_data};
    assign w_last_word = ({1'b0, r_widx} == (r_n - 1'b1));
    // A byte landing on the boundary cycle wins over the timeout
    assign w_timeout   = (r_state != S_IDLE) && !rx_valid
                         && (r_idle == TO_LAST);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_asm   <= '0;
            r_sum   <= '0;
            r_idle  <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_n     <= w_n;
            r_widx  <= w_widx;
            r_bidx  <= w_bidx;
            r_asm   <= w_asm;
            r_sum   <= w_sum;
            r_idle  <= w_idle;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_hold  <= w_hold;
            r_done  <= w_done;
            r_err   <= w_err;
        end
    end

    // Frame parser: next state, counters and registered outputs
    always_comb begin
        w_state = r_state;
        w_n     = r_n;
        w_widx  = r_widx;
        w_bidx  = r_bidx;
        w_asm   = r_asm;
        w_sum   = r_sum;
        w_we    = 1'b0;
        w_addr  = r_addr;
        w_wdata = r_wdata;
        w_hold  = r_hold;
        w_done  = 1'b0;
        w_err   = r_err;
        if (rx_valid || (r_state == S_IDLE)) begin
            w_idle = '0;
        end else begin
            w_idle = r_idle + 1'b1;
        end

        if (w_timeout) begin
            w_err   = 1'b1;
            w_state = S_IDLE;
            w_idle  = '0;
        end else if (rx_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (rx_data == SYNC) begin
                        w_state = S_COUNT;
                        w_hold  = 1'b1;
                        w_err   = 1'b0;
                        w_widx  = '0;
                        w_bidx  = '0;
                        w_sum   = '0;
                    end
                end
                S_COUNT: begin
                    if (rx_data == 8'h00) begin
                        w_n = N_FULL;
                    end else begin
                        w_n = NW'(rx_data);
                    end
                    w_bidx  = '0;
                    w_state = S_DATA;
                end
                S_DATA: begin
                    w_asm  = w_word[23:0];
                    w_sum  = r_sum + rx_data;
                    w_bidx = r_bidx + 1'b1;
                    if (r_bidx == 2'd3) begin
                        w_we    = 1'b1;
                        w_addr  = r_widx;
                        w_wdata = w_word;
                        w_widx  = r_widx + 1'b1;
                        if (w_last_word) begin
                            w_state = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (rx_data == r_sum) begin
                        w_done = 1'b1;
                        w_hold = 1'b0;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state = S_IDLE;
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader.
// Expected RAM writes are queued as bytes are driven and popped on imem_we.
module tb_imem_loader;

    localparam int AW = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;
    logic          busy;

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W (AW),
        .TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_wr   = 0;
    logic [AW+31:0] last_wr = '0;
    logic [AW+31:0] exp_q[$];
    logic [31:0]    wq[$];

    logic [7:0] basic [11] = '{8'hA5, 8'h02, 8'h20, 8'h1F, 8'h00, 8'h14,
                               8'h03, 8'hE0, 8'h00, 8'h08, 8'h3E};

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard side: every write must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            n_wr++;
            last_wr = {imem_addr, imem_wdata};
            if (exp_q.size() == 0) begin
                chk("wr_extra", 64'(exp_q.size()), 64'd1);
            end else begin
                chk("wr", {imem_addr, imem_wdata}, exp_q.pop_front());
            end
        end
        if (rst_n && load_done) begin
            n_done++;
            chk("hold_at_done", cpu_hold, 0);
        end
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_basic();
        for (int i = 0; i < 11; i++) begin
            if (i == 5) exp_q.push_back({8'd0, 32'h201F0014});
            if (i == 9) exp_q.push_back({8'd1, 32'h03E00008});
            send(basic[i]);
            if (i == 0) begin
                chk("basic_hold_sync", cpu_hold, 1);
                chk("basic_busy", busy, 1);
            end
        end
    endtask

    task automatic send_frame(input int n, input bit bad);
        logic [7:0]  sum;
        logic [31:0] w;
        logic [7:0]  b;
        sum = 8'h00;
        send(8'hA5);
        chk("sync_err_clr", load_err, 0);
        chk("sync_hold", cpu_hold, 1);
        send(8'(n));
        for (int k = 0; k < n; k++) begin
            w = wq[k];
            for (int j = 0; j < 4; j++) begin
                b = w[31-8*j -: 8];
                sum = sum + b;
                if (j == 3) exp_q.push_back({8'(k), w});
                send(b);
            end
        end
        send(bad ? (sum ^ 8'h01) : sum);
    endtask

    int d0, w0;

    initial begin
        // Reset state
        #12;
        chk("rst_outs", {imem_we, imem_addr, imem_wdata, cpu_hold,
                         load_done, load_err, busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("post_rst_outs", {imem_we, cpu_hold, load_err, busy}, 0);

        // Basic load
        d0 = n_done; w0 = n_wr;
        run_basic();
        settle();
        chk("basic_done", n_done - d0, 1);
        chk("basic_wr", n_wr - w0, 2);
        chk("basic_err", load_err, 0);
        chk("basic_hold", cpu_hold, 0);
        chk("basic_q", exp_q.size(), 0);

        // Bad checksum, then a good frame
        wq = '{32'h201F0014, 32'h03E00008};
        d0 = n_done; w0 = n_wr;
        send_frame(2, 1'b1);
        settle();
        chk("bad_done", n_done - d0, 0);
        chk("bad_wr", n_wr - w0, 2);
        chk("bad_err", load_err, 1);
        chk("bad_hold", cpu_hold, 1);
        chk("bad_busy", busy, 0);
        d0 = n_done;
        send_frame(2, 1'b0);
        settle();
        chk("recov_done", n_done - d0, 1);
        chk("recov_err", load_err, 0);
        chk("recov_hold", cpu_hold, 0);

        // Garbage before sync
        d0 = n_done; w0 = n_wr;
        send(8'h00); send(8'hFF); send(8'h5A);
        settle();
        chk("garb_hold", cpu_hold, 0);
        chk("garb_busy", busy, 0);
        chk("garb_wr", n_wr - w0, 0);
        run_basic();
        settle();
        chk("garb_done", n_done - d0, 1);
        chk("garb_err", load_err, 0);
        chk("garb_q", exp_q.size(), 0);

        // Timeout after a partial word
        w0 = n_wr;
        send(8'hA5); send(8'h01); send(8'h12); send(8'h34);
        repeat (TO - 1) @(posedge clk);
        #1;
        chk("to_early_err", load_err, 0);
        chk("to_early_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("to_err", load_err, 1);
        chk("to_busy", busy, 0);
        chk("to_hold", cpu_hold, 1);
        chk("to_wr", n_wr - w0, 0);

        // A byte just before the boundary keeps the load alive
        d0 = n_done;
        send(8'hA5);
        chk("to2_err_clr", load_err, 0);
        send(8'h01); send(8'h12); send(8'h34);
        repeat (TO - 2) @(posedge clk);
        send(8'h56);
        chk("to2_err", load_err, 0);
        chk("to2_busy", busy, 1);
        exp_q.push_back({8'd0, 32'h12345678});
        send(8'h78);
        send(8'h14);
        settle();
        chk("to2_done", n_done - d0, 1);
        chk("to2_hold", cpu_hold, 0);

        // Full-memory load
        wq.delete();
        for (int k = 0; k < 256; k++) wq.push_back(32'(k));
        d0 = n_done; w0 = n_wr;
        send_frame(256, 1'b0);
        settle();
        chk("full_wr", n_wr - w0, 256);
        chk("full_last", last_wr, {8'hFF, 32'h000000FF});
        chk("full_done", n_done - d0, 1);
        chk("full_q", exp_q.size(), 0);

        // Reset in the middle of the second word
        w0 = n_wr;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) exp_q.push_back({8'd0, 32'h201F0014});
            send(basic[i]);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {imem_we, imem_addr, imem_wdata, cpu_hold,
                             load_done, load_err, busy}, 0);
        chk("mid_rst_wr", n_wr - w0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        chk("mid_rst_q", exp_q.size(), 0);
        d0 = n_done; w0 = n_wr;
        run_basic();
        settle();
        chk("mid_rst_done", n_done - d0, 1);
        chk("mid_rst_wr2", n_wr - w0, 2);
        chk("mid_rst_hold", cpu_hold, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
